// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3-256 message front end.
package sha3_pkg;

    localparam int WORD_W     = 64;
    localparam int BN_W       = 3;
    localparam int RATE_BYTES = 136;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEND     = 2'd1,
        SEND_PAD = 2'd2,
        WAIT     = 2'd3
    } packer_state_t;

    // Bit offset of byte slot idx in a big-endian 64-bit word (slot 0 -> [63:56]).
    function automatic logic [5:0] byte_lsb(input logic [2:0] idx);
        return {3'd7 - idx, 3'b000};
    endfunction

endpackage

// File: rtl/sha3_msg_packer.sv
// Packs a byte stream big-endian into 64-bit words for the keccak core and
// appends the empty terminating word when a message ends on a word boundary.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FILL     | accepting bytes into the current word
//   SEND     | presenting the packed word until the core takes it
//   SEND_PAD | presenting the empty last word (message was a multiple of 8)
//   WAIT     | message complete, waiting for the digest (k_out_ready)
module sha3_msg_packer
    import sha3_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int BN_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [WORD_W-1:0] k_in,
    output logic              k_in_ready,
    output logic              k_is_last,
    output logic [BN_W-1:0]   k_byte_num,
    input  logic              k_buffer_full,
    input  logic              k_out_ready,
    output logic              busy
);

    packer_state_t     state;
    packer_state_t     state_nxt;
    logic [WORD_W-1:0] word;
    logic [2:0]        cnt;
    logic              pad_pend;
    logic              last_r;
    logic [BN_W-1:0]   bn_r;
    logic              byte_xfer;
    logic              word_xfer;

    assign byte_xfer = s_valid && s_ready;
    assign word_xfer = k_in_ready && !k_buffer_full;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (byte_xfer && (s_last || cnt == 3'd7)) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (word_xfer) begin
                    if (pad_pend) begin
                        state_nxt = SEND_PAD;
                    end else if (last_r) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            SEND_PAD: begin
                if (word_xfer) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (k_out_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Outputs decoded from state and registered word/flags only; k_buffer_full never reaches s_ready.
    always_comb begin
        s_ready    = 1'b0;
        k_in       = '0;
        k_in_ready = 1'b0;
        k_is_last  = 1'b0;
        k_byte_num = '0;
        busy       = 1'b0;
        unique case (state)
            FILL: begin
                s_ready = 1'b1;
                busy    = (cnt != 3'd0);
            end
            SEND: begin
                k_in       = word;
                k_in_ready = 1'b1;
                k_is_last  = last_r;
                k_byte_num = bn_r;
                busy       = 1'b1;
            end
            SEND_PAD: begin
                k_in_ready = 1'b1;
                k_is_last  = 1'b1;
                busy       = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Byte packing, fill count and end-of-message bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word     <= '0;
            cnt      <= '0;
            pad_pend <= 1'b0;
            last_r   <= 1'b0;
            bn_r     <= '0;
        end else begin
            if (byte_xfer) begin
                // First byte of a word clears the unfilled tail to zero.
                if (cnt == 3'd0) begin
                    word <= {s_data, {(WORD_W-8){1'b0}}};
                end else begin
                    word[byte_lsb(cnt) +: 8] <= s_data;
                end
                if (s_last) begin
                    cnt <= '0;
                    if (cnt == 3'd7) begin
                        // Full last word: the core still needs an empty is_last word.
                        pad_pend <= 1'b1;
                        last_r   <= 1'b0;
                        bn_r     <= '0;
                    end else begin
                        pad_pend <= 1'b0;
                        last_r   <= 1'b1;
                        bn_r     <= BN_W'(cnt) + BN_W'(1);
                    end
                end else begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        last_r <= 1'b0;
                        bn_r   <= '0;
                    end
                end
            end
            if (state == SEND && word_xfer) begin
                pad_pend <= 1'b0;
            end
        end
    end

    // Interface invariants toward the core.
    a_last_gated: assert property (@(posedge clk) disable iff (!reset_n)
        !k_in_ready |-> (!k_is_last && k_byte_num == '0));

    a_hold_on_full: assert property (@(posedge clk) disable iff (!reset_n)
        (k_in_ready && k_buffer_full) |=>
            (k_in_ready && $stable(k_in) && $stable(k_is_last) && $stable(k_byte_num)));

    a_no_byte_while_sending: assert property (@(posedge clk) disable iff (!reset_n)
        k_in_ready |-> !s_ready);

endmodule
